// File: rtl/uart_tx_arbiter_if.sv
// Bus between N byte requesters, the arbiter and one UART transmit core.
// The arbiter connects through the master modport. A requester/TX-core
// model connects through the slave modport.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  localparam int OW = $clog2(N);

  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   last;
  logic [N-1:0]   ack;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [OW-1:0]  owner;
  logic           locked;
  logic           to_err;

  modport master (
    input  req, data, last, tx_busy,
    output ack, tx_start, tx_data, owner, locked, to_err
  );

  modport slave (
    output req, data, last, tx_busy,
    input  ack, tx_start, tx_data, owner, locked, to_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N requesters.
// When a requester presents a byte with last=0, it keeps the grant until it
// sends a byte with last=1, or until its packet stalls for LOCK_TO idle cycles.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int LOCK_TO = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam int OW = $clog2(N);
  localparam int CW = $clog2(LOCK_TO + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } state_t;

  state_t        state;
  logic [OW-1:0] rr_ptr;
  logic [CW-1:0] to_cnt;
  logic          last_q;

  logic          any_req;
  logic          owner_req;
  logic          do_grant;
  logic          to_hit;
  logic [OW-1:0] rr_pick;
  logic [OW-1:0] grant_idx;
  logic [7:0]    grant_byte;
  logic          grant_last;
  logic [N-1:0]  grant_onehot;

  // Return the next requester index, wrapping from N-1 back to 0.
  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] x);
    if (int'(x) == N - 1) begin
      return '0;
    end
    return x + 1'b1;
  endfunction

  // Return the first set request bit at or after ptr, searching modulo N.
  function automatic logic [OW-1:0] rr_select(input logic [N-1:0] r,
                                              input logic [OW-1:0] ptr);
    logic [OW-1:0] sel;
    logic          found;
    int            idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && r[idx]) begin
        sel   = OW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Choose the grant candidate. While a packet is locked, only its owner is eligible.
  always_comb begin
    any_req      = |bus.req;
    owner_req    = bus.req[bus.owner];
    rr_pick      = rr_select(bus.req, rr_ptr);
    grant_idx    = bus.locked ? bus.owner : rr_pick;
    do_grant     = !bus.tx_busy && (bus.locked ? owner_req : any_req);
    to_hit       = bus.locked && !owner_req && (to_cnt == CW'(LOCK_TO - 1));
    grant_byte   = bus.data[int'(grant_idx)*8 +: 8];
    grant_last   = bus.last[grant_idx];
    grant_onehot = '0;
    grant_onehot[grant_idx] = 1'b1;
  end

  // Main FSM. It registers every output. Pulse outputs default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      to_cnt       <= '0;
      last_q       <= 1'b0;
      bus.ack      <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.owner    <= '0;
      bus.locked   <= 1'b0;
      bus.to_err   <= 1'b0;
    end else begin
      bus.ack      <= '0;
      bus.tx_start <= 1'b0;
      bus.to_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (do_grant) begin
            bus.owner    <= grant_idx;
            bus.tx_data  <= grant_byte;
            bus.ack      <= grant_onehot;
            bus.tx_start <= 1'b1;
            last_q       <= grant_last;
            state        <= START;
          end else if (to_hit) begin
            bus.locked <= 1'b0;
            bus.to_err <= 1'b1;
            rr_ptr     <= wrap_inc(bus.owner);
            to_cnt     <= '0;
          end else if (bus.locked && !owner_req) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        START: begin
          to_cnt <= '0;
          if (last_q) begin
            bus.locked <= 1'b0;
            rr_ptr     <= wrap_inc(bus.owner);
          end else begin
            bus.locked <= 1'b1;
          end
          state <= BUSY;
        end
        BUSY: begin
          if (!bus.tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with N=4 and LOCK_TO=20.
// The bench models the TX core. It holds tx_busy for BUSY_LEN cycles after each tx_start.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int LOCK_TO  = 20;
  localparam int BUSY_LEN = 10;

  logic clk;
  logic rst_n;
  logic manual_busy;
  int   busy_cnt;
  int   errors = 0;
  int   checks = 0;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(.N(N), .LOCK_TO(LOCK_TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TX core model: it asserts busy in the cycle after tx_start and holds it for BUSY_LEN cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (bus.tx_start === 1'b1) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign bus.tx_busy = manual_busy | (busy_cnt != 0);

  // Watchdog: stops the run if the simulation hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic present(input int i, input logic [7:0] b, input logic l);
    bus.data[8*i +: 8] = b;
    bus.last[i]        = l;
    bus.req[i]         = 1'b1;
  endtask

  task automatic drop(input int i);
    bus.req[i] = 1'b0;
  endtask

  task automatic do_reset;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.last    = '0;
    bus.data    = '0;
    manual_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int max_cycles, output bit ok, output int acks);
    ok   = 1'b0;
    acks = 0;
    for (int c = 0; c < max_cycles; c++) begin
      @(posedge clk); #1;
      acks += $countones(bus.ack);
      if (bus.tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Checks the reset values while requests are active.
  task automatic test_reset;
    rst_n       = 1'b0;
    manual_busy = 1'b0;
    bus.req     = '1;
    bus.last    = '1;
    bus.data    = 32'hAABBCCDD;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
    checks++; if (bus.ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0000", bus.ack); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    checks++; if (bus.owner !== 2'd0) begin errors++; $display("[TB] FAIL reset_owner: got %0d expected 0", bus.owner); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b expected 0", bus.locked); end
    checks++; if (bus.to_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_to_err: got %b expected 0", bus.to_err); end
  endtask

  // Tests a single byte, its one-cycle latency, and the round-robin pointer afterwards.
  task automatic test_single;
    bit ok;
    int acks;
    do_reset();
    present(0, 8'h41, 1'b1);
    tick();
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("[TB] FAIL single_tx_start: got %b expected 1", bus.tx_start); end
    checks++; if (bus.ack !== 4'b0001) begin errors++; $display("[TB] FAIL single_ack: got %b expected 0001", bus.ack); end
    checks++; if (bus.tx_data !== 8'h41) begin errors++; $display("[TB] FAIL single_tx_data: got %h expected 41", bus.tx_data); end
    checks++; if (bus.owner !== 2'd0) begin errors++; $display("[TB] FAIL single_owner: got %0d expected 0", bus.owner); end
    drop(0);
    tick();
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL single_start_pulse: got %b expected 0", bus.tx_start); end
    checks++; if (bus.ack !== 4'b0000) begin errors++; $display("[TB] FAIL single_ack_pulse: got %b expected 0000", bus.ack); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL single_locked: got %b expected 0", bus.locked); end
    present(0, 8'h50, 1'b1);
    present(1, 8'h51, 1'b1);
    wait_start(40, ok, acks);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL single_rr_timeout: got %b expected 1", ok); end
    checks++; if (bus.owner !== 2'd1) begin errors++; $display("[TB] FAIL single_rr_owner: got %0d expected 1", bus.owner); end
    checks++; if (bus.tx_data !== 8'h51) begin errors++; $display("[TB] FAIL single_rr_data: got %h expected 51", bus.tx_data); end
    drop(1);
    wait_start(40, ok, acks);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL single_second_timeout: got %b expected 1", ok); end
    checks++; if (bus.owner !== 2'd0) begin errors++; $display("[TB] FAIL single_second_owner: got %0d expected 0", bus.owner); end
    checks++; if (bus.tx_data !== 8'h50) begin errors++; $display("[TB] FAIL single_second_data: got %h expected 50", bus.tx_data); end
    drop(0);
  endtask

  // Tests fair rotation with every requester held high, including the wrap from 3 to 0.
  task automatic test_round_robin;
    bit   ok;
    int   acks;
    int   total_acks;
    int   exp_owner [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_data;
    logic [3:0] exp_ack;
    do_reset();
    for (int i = 0; i < N; i++) present(i, 8'hA0 + 8'(i), 1'b1);
    total_acks = 0;
    for (int g = 0; g < 5; g++) begin
      wait_start(40, ok, acks);
      total_acks += acks;
      exp_data = 8'hA0 + 8'(exp_owner[g]);
      exp_ack  = 4'b0001 << exp_owner[g];
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rr_timeout[%0d]: got %b expected 1", g, ok); end
      checks++; if (bus.owner !== 2'(exp_owner[g])) begin errors++; $display("[TB] FAIL rr_owner[%0d]: got %0d expected %0d", g, bus.owner, exp_owner[g]); end
      checks++; if (bus.tx_data !== exp_data) begin errors++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", g, bus.tx_data, exp_data); end
      checks++; if (bus.ack !== exp_ack) begin errors++; $display("[TB] FAIL rr_ack[%0d]: got %b expected %b", g, bus.ack, exp_ack); end
    end
    checks++; if (total_acks !== 5) begin errors++; $display("[TB] FAIL rr_ack_count: got %0d expected 5", total_acks); end
    bus.req = '0;
  endtask

  // Tests a locked two-byte packet from requester 2 that holds off requesters 3 and 0.
  task automatic test_lock;
    bit ok;
    int acks;
    do_reset();
    present(2, 8'h10, 1'b0);
    present(3, 8'h33, 1'b1);
    wait_start(40, ok, acks);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL lock_first_timeout: got %b expected 1", ok); end
    checks++; if (bus.owner !== 2'd2) begin errors++; $display("[TB] FAIL lock_first_owner: got %0d expected 2", bus.owner); end
    checks++; if (bus.tx_data !== 8'h10) begin errors++; $display("[TB] FAIL lock_first_data: got %h expected 10", bus.tx_data); end
    present(2, 8'h11, 1'b1);
    present(0, 8'h44, 1'b1);
    tick();
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL lock_set: got %b expected 1", bus.locked); end
    wait_start(40, ok, acks);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL lock_second_timeout: got %b expected 1", ok); end
    checks++; if (bus.owner !== 2'd2) begin errors++; $display("[TB] FAIL lock_second_owner: got %0d expected 2", bus.owner); end
    checks++; if (bus.tx_data !== 8'h11) begin errors++; $display("[TB] FAIL lock_second_data: got %h expected 11", bus.tx_data); end
    drop(2);
    tick();
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_clear: got %b expected 0", bus.locked); end
    wait_start(40, ok, acks);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL lock_third_timeout: got %b expected 1", ok); end
    checks++; if (bus.owner !== 2'd3) begin errors++; $display("[TB] FAIL lock_third_owner: got %0d expected 3", bus.owner); end
    checks++; if (bus.tx_data !== 8'h33) begin errors++; $display("[TB] FAIL lock_third_data: got %h expected 33", bus.tx_data); end
    drop(3);
    wait_start(40, ok, acks);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL lock_fourth_timeout: got %b expected 1", ok); end
    checks++; if (bus.owner !== 2'd0) begin errors++; $display("[TB] FAIL lock_fourth_owner: got %0d expected 0", bus.owner); end
    checks++; if (bus.tx_data !== 8'h44) begin errors++; $display("[TB] FAIL lock_fourth_data: got %h expected 44", bus.tx_data); end
    drop(0);
  endtask

  // Tests a stalled locked packet that is released after LOCK_TO idle cycles.
  // Tick 12 after the grant is the first IDLE edge. Ticks 13..32 are the 20 counted cycles.
  task automatic test_timeout;
    int seen_at;
    bit early_start;
    do_reset();
    present(1, 8'h55, 1'b0);
    tick();
    checks++; if (bus.tx_start !== 1'b1 || bus.owner !== 2'd1) begin errors++; $display("[TB] FAIL to_grant: got start=%b owner=%0d expected start=1 owner=1", bus.tx_start, bus.owner); end
    drop(1);
    present(0, 8'h66, 1'b1);
    seen_at     = -1;
    early_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus.tx_start === 1'b1) early_start = 1'b1;
      if (bus.to_err === 1'b1) begin
        seen_at = c;
        break;
      end
    end
    checks++; if (seen_at !== 32) begin errors++; $display("[TB] FAIL to_cycle: got %0d expected 32", seen_at); end
    checks++; if (early_start !== 1'b0) begin errors++; $display("[TB] FAIL to_no_start: got %b expected 0", early_start); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL to_unlocked: got %b expected 0", bus.locked); end
    tick();
    checks++; if (bus.to_err !== 1'b0) begin errors++; $display("[TB] FAIL to_err_pulse: got %b expected 0", bus.to_err); end
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("[TB] FAIL to_next_start: got %b expected 1", bus.tx_start); end
    checks++; if (bus.owner !== 2'd0) begin errors++; $display("[TB] FAIL to_next_owner: got %0d expected 0", bus.owner); end
    checks++; if (bus.tx_data !== 8'h66) begin errors++; $display("[TB] FAIL to_next_data: got %h expected 66", bus.tx_data); end
    drop(0);
  endtask

  // Tests an asynchronous reset during BUSY and the grant on the first edge after release.
  task automatic test_reset_busy;
    do_reset();
    present(0, 8'h41, 1'b0);
    tick();
    drop(0);
    repeat (3) tick();
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL rb_locked_before: got %b expected 1", bus.locked); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL rb_locked: got %b expected 0", bus.locked); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL rb_tx_data: got %h expected 00", bus.tx_data); end
    checks++; if (bus.owner !== 2'd0 || bus.ack !== 4'b0000 || bus.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL rb_outputs: got owner=%0d ack=%b start=%b expected 0/0000/0", bus.owner, bus.ack, bus.tx_start); end
    present(2, 8'h22, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("[TB] FAIL rb_start: got %b expected 1", bus.tx_start); end
    checks++; if (bus.owner !== 2'd2) begin errors++; $display("[TB] FAIL rb_owner: got %0d expected 2", bus.owner); end
    checks++; if (bus.ack !== 4'b0100) begin errors++; $display("[TB] FAIL rb_ack: got %b expected 0100", bus.ack); end
    checks++; if (bus.tx_data !== 8'h22) begin errors++; $display("[TB] FAIL rb_data: got %h expected 22", bus.tx_data); end
    drop(2);
  endtask

  // Tests that no grant is issued while tx_busy stays high, and that a grant follows as soon as it falls.
  task automatic test_busy_hold;
    bit seen;
    do_reset();
    manual_busy = 1'b1;
    present(3, 8'h77, 1'b1);
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (bus.tx_start === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL hold_no_start: got %b expected 0", seen); end
    manual_busy = 1'b0;
    tick();
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("[TB] FAIL hold_start: got %b expected 1", bus.tx_start); end
    checks++; if (bus.owner !== 2'd3) begin errors++; $display("[TB] FAIL hold_owner: got %0d expected 3", bus.owner); end
    checks++; if (bus.tx_data !== 8'h77) begin errors++; $display("[TB] FAIL hold_data: got %h expected 77", bus.tx_data); end
    drop(3);
  endtask

  // Runs every scenario in sequence and prints the summary.
  initial begin
    rst_n       = 1'b0;
    manual_busy = 1'b0;
    bus.req     = '0;
    bus.last    = '0;
    bus.data    = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_busy();
    test_busy_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter LOCK_TO, default 1000, idle cycles allowed between bytes of a locked packet before forced release.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  N  per-requester byte request; held high until the matching ack.
REQ-006 data  input  8*N  per-requester byte; requester i uses bits [8i+7:8i]; stable while req[i] is high.
REQ-007 last  input  N  per-requester end-of-packet flag for the presented byte.
REQ-008 ack  output  N  one-cycle pulse: byte of requester i accepted.
REQ-009 tx_start  output  1  one-cycle pulse to the UART TX core.
REQ-010 tx_data  output  8  byte to the UART TX core; valid while tx_start is high.
REQ-011 tx_busy  input  1  UART TX core busy; core raises it in the cycle after tx_start and holds it through the stop bit.
REQ-012 owner  output  clog2(N)  index of the current or last granted requester.
REQ-013 locked  output  1  a multi-byte packet is in progress and the grant is held.
REQ-014 to_err  output  1  one-cycle pulse: lock released by timeout.

Function
REQ-015 FSM states: IDLE, START, BUSY.
REQ-016 IDLE, locked=0, tx_busy=0, any req high: select the first set req bit at or after rr_ptr, wrapping modulo N; register tx_data and owner; go to START.
REQ-017 IDLE, locked=1, tx_busy=0: consider only req[owner]; all other requests wait.
REQ-018 START lasts exactly one cycle: tx_start=1, ack[owner]=1, all other ack bits 0; next state BUSY.
REQ-019 Latency: req sampled high in IDLE at edge k; tx_start and ack high in cycle k+1.
REQ-020 START, last[owner]=0: set locked=1.
REQ-021 START, last[owner]=1: clear locked and set rr_ptr=(owner+1) mod N.
REQ-022 BUSY: stay while tx_busy=1; go to IDLE on the first cycle with tx_busy=0.
REQ-023 IDLE with tx_busy=1: no grant issued; state stays IDLE.
REQ-024 Timeout counter: clears on every START; increments each cycle in IDLE while locked=1 and req[owner]=0.
REQ-025 Counter reaching LOCK_TO: clear locked, rr_ptr=(owner+1) mod N, to_err=1 for one cycle, counter cleared; no byte sent that cycle.
REQ-026 Same-cycle owner req and timeout: the req wins; the byte is granted and to_err stays 0.
REQ-027 Simultaneous requests: only the round-robin winner is acked; losers remain pending with no loss.
REQ-028 Owner wrap: N-1 wraps to 0.
REQ-029 A req rising while in START or BUSY is evaluated on return to IDLE.
REQ-030 All outputs are registered; no combinational path from req to ack or tx_start.

Reset
REQ-031 rst_n low forces immediately: state IDLE; ack=0, tx_start=0, tx_data=0x00, owner=0, locked=0, to_err=0, rr_ptr=0, counter=0.
REQ-032 Reset mid-START or mid-BUSY aborts the grant; no ack is issued for the in-flight byte, and the lock is dropped.
REQ-033 After rst_n rises, the first grant can occur at the first clock edge with rst_n high.

Verification
REQ-034 req=0b0001, data0=0x41, last0=1 -> tx_start with tx_data=0x41 and ack=0b0001 one cycle later; locked=0; rr_ptr=1.
REQ-035 req=0b1111 held, all last=1, tx_busy=10-cycle pulses -> grant order 0,1,2,3,0; one ack per byte.
REQ-036 Requester 2 sends 0x10 (last=0); req3 high throughout; requester 2 then sends 0x11 (last=1) -> tx_data 0x10, 0x11, then requester 3's byte.
REQ-037 Requester 1 sends a byte with last=0, then drops req; LOCK_TO=20 -> to_err pulse after 20 idle cycles; locked=0; pending req0 granted next.
REQ-038 rst_n pulsed low during BUSY -> outputs at reset values in the same cycle; after release with req=0b0100, owner=2 is granted.
REQ-039 tx_busy held high with req pending -> no tx_start; grant occurs in the cycle after tx_busy falls.
